// File: rtl/nes_joypad_pkg.sv
// Shared types and constants for the NES joypad poller.
package nes_joypad_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STROBE = 3'd1,
    WAIT0  = 3'd2,
    CLK_HI = 3'd3,
    CLK_LO = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Bit positions in o_buttons (8-bit NES pad ordering).
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; reset value selectable.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clock,
  input  logic R_reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; the output is safe to use one cycle after the first.
  always_ff @(posedge clock) begin
    if (R_reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nes_joypad_poller.sv
// Console-side scanner for a CD4021-based NES pad: periodic latch/shift cycle,
// active-low serial sampling, active-high button word plus presence flag.
module nes_joypad_poller
  import nes_joypad_pkg::*;
#(
  parameter int C_bits        = 8,
  parameter int C_strobe_clks = 256,
  parameter int C_half_clks   = 128,
  parameter int C_poll_clks   = 357142
) (
  input  logic              clock,
  input  logic              R_reset,
  input  logic              i_trigger,
  input  logic              i_joy_data,
  output logic              o_joy_strobe,
  output logic              o_joy_clock,
  output logic [C_bits-1:0] o_buttons,
  output logic              o_present,
  output logic              o_valid,
  output logic              o_busy
);

  localparam int PH_MAX    = (C_strobe_clks > C_half_clks) ? C_strobe_clks : C_half_clks;
  localparam int PH_W      = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int K_W       = $clog2(C_bits + 1);
  localparam int POLL_W    = $clog2(C_poll_clks);
  localparam int SCAN_CLKS = C_strobe_clks + C_half_clks + 2 * C_bits * C_half_clks + 1;

  // A poll period shorter than a scan would make every periodic tick collide with a scan.
  if (C_poll_clks <= SCAN_CLKS) begin : g_poll_chk
    $error("C_poll_clks must exceed the scan duration");
  end

  state_t              state, state_n;
  logic [PH_W-1:0]     ph, ph_n;
  logic [K_W-1:0]      k, k_n;
  logic [POLL_W-1:0]   poll;
  logic [C_bits-1:0]   samp;
  logic                d_s;
  logic                capture;
  logic                finish;
  logic                start;
  logic                ph_last_strobe;
  logic                ph_last_half;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clock   (clock),
    .R_reset (R_reset),
    .d       (i_joy_data),
    .q       (d_s)
  );

  assign start          = (poll == '0) || i_trigger;
  assign ph_last_strobe = (ph == PH_W'(C_strobe_clks - 1));
  assign ph_last_half   = (ph == PH_W'(C_half_clks - 1));
  assign finish         = (state_n == DONE);
  assign o_busy         = (state != IDLE);

  // Free-running poll timer; its zero value is the periodic scan request.
  always_ff @(posedge clock) begin
    if (R_reset)                              poll <= '0;
    else if (poll == POLL_W'(C_poll_clks - 1)) poll <= '0;
    else                                      poll <= poll + 1'b1;
  end

  // Next-state, phase timer and sample-capture decode.
  always_comb begin
    state_n = state;
    ph_n    = ph + 1'b1;
    k_n     = k;
    capture = 1'b0;
    case (state)
      IDLE: begin
        ph_n = '0;
        k_n  = '0;
        if (start) state_n = STROBE;
      end
      STROBE: begin
        if (ph_last_strobe) begin
          state_n = WAIT0;
          ph_n    = '0;
        end
      end
      WAIT0: begin
        if (ph_last_half) begin
          capture = 1'b1;
          state_n = CLK_HI;
          k_n     = K_W'(1);
          ph_n    = '0;
        end
      end
      CLK_HI: begin
        if (ph_last_half) begin
          state_n = CLK_LO;
          ph_n    = '0;
        end
      end
      CLK_LO: begin
        if (ph_last_half) begin
          capture = 1'b1;
          ph_n    = '0;
          if (k < K_W'(C_bits)) begin
            k_n     = k + 1'b1;
            state_n = CLK_HI;
          end else begin
            state_n = DONE;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        ph_n    = '0;
        k_n     = '0;
      end
      default: begin
        state_n = IDLE;
        ph_n    = '0;
        k_n     = '0;
      end
    endcase
  end

  // State, sample shift register, and pad-facing/result outputs (registered off next state).
  always_ff @(posedge clock) begin
    if (R_reset) begin
      state        <= IDLE;
      ph           <= '0;
      k            <= '0;
      samp         <= '1;
      o_joy_strobe <= 1'b0;
      o_joy_clock  <= 1'b0;
      o_valid      <= 1'b0;
      o_buttons    <= '0;
      o_present    <= 1'b0;
    end else begin
      state        <= state_n;
      ph           <= ph_n;
      k            <= k_n;
      o_joy_strobe <= (state_n == STROBE);
      o_joy_clock  <= (state_n == CLK_HI);
      o_valid      <= (state_n == DONE);
      // Samples enter at the top so s0 ends up at bit 0 after C_bits captures.
      if (capture && !finish) samp <= {d_s, samp[C_bits-1:1]};
      // Final sample is the presence line: a pad shifts in ground, the pull-up reads high.
      if (finish) begin
        o_present <= ~d_s;
        o_buttons <= d_s ? '0 : ~samp;
      end
    end
  end

endmodule

// File: tb/tb_nes_joypad_poller.sv
// Scoreboard bench: two pollers (8- and 16-bit) with CD4021 pad models,
// expected scan results predicted from scheduling rules and queued per start.
module tb_nes_joypad_poller;
  import nes_joypad_pkg::*;

  localparam int STB  = 4;
  localparam int HALF = 2;
  localparam int POLL = 100;

  typedef struct {
    int          d;
    int          cyc;
    logic [15:0] btn;
    logic        prs;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        R_reset, i_trigger;
  logic        joy_a, joy_b;
  logic        stb_a, jck_a, prs_a, vld_a, bsy_a;
  logic        stb_b, jck_b, prs_b, vld_b, bsy_b;
  logic [7:0]  btn_a;
  logic [15:0] btn_b;

  logic        stb[2], jck[2], prs[2], vld[2], bsy[2];
  logic [15:0] btn[2];
  assign stb[0] = stb_a;  assign stb[1] = stb_b;
  assign jck[0] = jck_a;  assign jck[1] = jck_b;
  assign prs[0] = prs_a;  assign prs[1] = prs_b;
  assign vld[0] = vld_a;  assign vld[1] = vld_b;
  assign bsy[0] = bsy_a;  assign bsy[1] = bsy_b;
  assign btn[0] = {8'h00, btn_a};
  assign btn[1] = btn_b;

  nes_joypad_poller #(.C_bits(8), .C_strobe_clks(STB), .C_half_clks(HALF), .C_poll_clks(POLL)) dut_a (
    .clock(clock), .R_reset(R_reset), .i_trigger(i_trigger), .i_joy_data(joy_a),
    .o_joy_strobe(stb_a), .o_joy_clock(jck_a), .o_buttons(btn_a), .o_present(prs_a),
    .o_valid(vld_a), .o_busy(bsy_a));

  nes_joypad_poller #(.C_bits(16), .C_strobe_clks(STB), .C_half_clks(HALF), .C_poll_clks(POLL)) dut_b (
    .clock(clock), .R_reset(R_reset), .i_trigger(i_trigger), .i_joy_data(joy_b),
    .o_joy_strobe(stb_b), .o_joy_clock(jck_b), .o_buttons(btn_b), .o_present(prs_b),
    .o_valid(vld_b), .o_busy(bsy_b));

  // Pad models: parallel load while latched, shift on rising joy clock, ground shifts in.
  logic [15:0] cfg[2];
  logic        conn[2];
  logic [16:0] sr_a = '1, sr_b = '1;
  always @(posedge stb_a or posedge jck_a)
    if (stb_a) sr_a <= {9'b0, ~cfg[0][7:0]};
    else       sr_a <= {1'b0, sr_a[16:1]};
  always @(posedge stb_b or posedge jck_b)
    if (stb_b) sr_b <= {1'b0, ~cfg[1]};
    else       sr_b <= {1'b0, sr_b[16:1]};
  assign joy_a = conn[0] ? sr_a[0] : 1'b1;
  assign joy_b = conn[1] ? sr_b[0] : 1'b1;

  // Cycle index since the last reset edge (cycle 0 = first cycle with reset low).
  int cyc = 0;
  always @(posedge clock) if (R_reset) cyc <= 0; else cyc <= cyc + 1;

  exp_t sb[$];
  int   checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, req);
    end
  endtask

  function automatic int nbits(input int d);
    return (d == 0) ? 8 : 16;
  endfunction

  // Monitor: protocol shape checks and scoreboard pops on o_valid.
  initial begin
    int  stb_run[2], ck_run[2], pulses[2];
    bit  ovl[2];
    logic stb_p[2], jck_p[2];
    forever begin
      @(negedge clock);
      for (int d = 0; d < 2; d++) begin
        int idx;
        if (R_reset) begin
          stb_run[d] = 0; ck_run[d] = 0; pulses[d] = 0; ovl[d] = 0;
          stb_p[d] = 1'b0; jck_p[d] = 1'b0;
        end else begin
          if (stb[d] && jck[d]) ovl[d] = 1;
          if (stb[d]) stb_run[d]++;
          else if (stb_p[d]) begin
            chk(d ? "b_strobe_width" : "a_strobe_width", stb_run[d], STB);
            stb_run[d] = 0;
          end
          if (jck[d]) begin
            ck_run[d]++;
            if (!jck_p[d]) pulses[d]++;
          end else if (jck_p[d]) begin
            chk(d ? "b_jclk_high" : "a_jclk_high", ck_run[d], HALF);
            ck_run[d] = 0;
          end
          stb_p[d] = stb[d];
          jck_p[d] = jck[d];
          idx = -1;
          for (int i = 0; i < sb.size(); i++)
            if (sb[i].d == d) begin idx = i; break; end
          if (vld[d]) begin
            if (idx < 0) begin
              checks++; failures++;
              $display("FAIL unexpected_valid dut=%0d cycle=%0d got=valid expected=no scan", d, cyc);
            end else begin
              chk(d ? "b_valid_cycle" : "a_valid_cycle", cyc, sb[idx].cyc);
              chk(d ? "b_buttons" : "a_buttons", btn[d], sb[idx].btn);
              chk(d ? "b_present" : "a_present", prs[d], sb[idx].prs);
              chk(d ? "b_clk_pulses" : "a_clk_pulses", pulses[d], nbits(d));
              chk(d ? "b_overlap" : "a_overlap", ovl[d], 0);
              chk(d ? "b_busy_done" : "a_busy_done", bsy[d], 1);
              sb.delete(idx);
            end
            pulses[d] = 0;
            ovl[d] = 0;
          end else if (idx >= 0 && cyc > sb[idx].cyc) begin
            checks++; failures++;
            $display("FAIL valid_missing dut=%0d cycle=%0d got=none expected=cycle %0d", d, cyc, sb[idx].cyc);
            sb.delete(idx);
          end
        end
      end
    end
  end

  // Reference schedule: a scan starts when idle and (poll slot or trigger); busy requests are lost.
  int nfree[2];
  int nscan[2] = '{0, 0};

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic plan(input bit trig);
    i_trigger = trig;
    for (int d = 0; d < 2; d++) begin
      if (cyc >= nfree[d] && ((cyc % POLL) == 0 || trig)) begin
        exp_t e;
        int   lat;
        if (nscan[d] == 0) begin
          cfg[d]  = (d == 0) ? 16'((1 << BTN_A) | (1 << BTN_START) | (1 << BTN_LEFT)) : 16'hAAAA;
          conn[d] = 1'b1;
        end else if (d == 0 && nscan[d] == 1) begin
          cfg[d]  = 16'($urandom) & 16'h00FF;
          conn[d] = 1'b0;
        end else begin
          cfg[d]  = 16'($urandom) & ((d == 0) ? 16'h00FF : 16'hFFFF);
          conn[d] = ($urandom_range(3) != 0);
        end
        lat     = STB + HALF + 2 * nbits(d) * HALF + 1;
        e.d     = d;
        e.cyc   = cyc + lat;
        e.btn   = conn[d] ? cfg[d] : 16'h0;
        e.prs   = conn[d];
        sb.push_back(e);
        nfree[d] = cyc + lat + 1;
        nscan[d]++;
      end
    end
  endtask

  task automatic chk_cleared(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_strobe"},  stb[d], 0);
      chk({tag, "_jclk"},    jck[d], 0);
      chk({tag, "_buttons"}, btn[d], 0);
      chk({tag, "_present"}, prs[d], 0);
      chk({tag, "_valid"},   vld[d], 0);
      chk({tag, "_busy"},    bsy[d], 0);
    end
  endtask

  initial begin
    R_reset   = 1'b1;
    i_trigger = 1'b0;
    cfg[0] = '0; cfg[1] = '0;
    conn[0] = 1'b1; conn[1] = 1'b1;
    repeat (3) step();
    chk_cleared("reset");
    R_reset  = 1'b0;
    nfree[0] = 0; nfree[1] = 0;
    plan(1'b0);
    // Free run with a trigger while busy (20) and one while idle (50).
    while (cyc < 415) begin
      step();
      plan(cyc == 20 || cyc == 50);
    end
    // Cycle 415 is the high phase of bit 3 on both pollers; reset lands mid-scan.
    chk("a_jclk_bit3", jck[0], 1);
    chk("b_jclk_bit3", jck[1], 1);
    R_reset   = 1'b1;
    i_trigger = 1'b0;
    step();
    chk_cleared("midreset");
    sb.delete();
    R_reset  = 1'b0;
    nfree[0] = 0; nfree[1] = 0;
    plan(1'b0);
    // Restart with sparse random triggers, then quiet until all scans drain.
    while (cyc < 199) begin
      step();
      plan(cyc < 120 && $urandom_range(63) == 0);
    end
    i_trigger = 1'b0;
    while (sb.size() > 0) begin
      checks++; failures++;
      $display("FAIL leftover_scan dut=%0d got=none expected=valid at cycle %0d", sb[0].d, sb[0].cyc);
      sb.delete(0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
